// File: rtl/risc_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, redirect input,
// and the instruction handshake toward decode.
interface risc_fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr_32;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data_32;
  logic        redirect_en;
  logic [31:0] redirect_pc_32;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_32;
  logic [31:0] pc_32;
  logic        misalign_1;

  // Fetch unit side.
  modport master (
    output imem_req_valid, imem_addr_32, instr_valid, instr_32, pc_32, misalign_1,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data_32, redirect_en, redirect_pc_32,
           instr_ready
  );

  // Memory / decode / redirect-source side.
  modport slave (
    input  imem_req_valid, imem_addr_32, instr_valid, instr_32, pc_32, misalign_1,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data_32, redirect_en, redirect_pc_32,
           instr_ready
  );
endinterface

// File: rtl/risc_fetch_unit.sv
// Instruction fetch stage: holds the fetch PC, issues one word request at a
// time to instruction memory, buffers {pc, instr} pairs in a small FIFO for
// decode, and handles PC redirects by flushing the buffer and squashing any
// in-flight response.
module risc_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input logic             clk,
  input logic             rst,
  risc_fetch_unit_if.master bus
);

  localparam logic [31:0] Nop  = 32'h0000_0013;
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  localparam ptr_t LastPtr  = ptr_t'(FIFO_DEPTH - 1);
  localparam cnt_t DepthCnt = cnt_t'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StSquash} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  ptr_t        rd_ptr_q, rd_ptr_d;
  ptr_t        wr_ptr_q, wr_ptr_d;
  cnt_t        count_q, count_d;
  logic        misalign_q, misalign_d;

  logic [31:0] instr_mem_q [FIFO_DEPTH];
  logic [31:0] pc_mem_q    [FIFO_DEPTH];

  logic        fifo_empty;
  logic        push;
  logic        pop;
  logic [31:0] target_pc;
  cnt_t        count_after_push;

  assign fifo_empty = (count_q == '0);
  assign pop        = ~fifo_empty & bus.instr_ready;
  assign target_pc  = {bus.redirect_pc_32[31:2], 2'b00};
  // Occupancy once a response lands this cycle, net of a same-cycle pop. Only
  // consulted in StWait, where the reserved slot guarantees count_q < depth.
  assign count_after_push = count_q + cnt_t'(1) - cnt_t'(pop);

  // Fetch FSM: next state, next fetch PC and the FIFO push strobe.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    push       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.redirect_en) begin
          fetch_pc_d = target_pc;
        end else if (count_q < DepthCnt) begin
          state_d = StReq;
        end
      end
      StReq: begin
        if (bus.redirect_en) begin
          fetch_pc_d = target_pc;
          state_d    = StIdle;
        end else if (bus.imem_req_ready) begin
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = StWait;
        end
      end
      StWait: begin
        if (bus.imem_rsp_valid && bus.redirect_en) begin
          fetch_pc_d = target_pc;
          state_d    = StIdle;
        end else if (bus.imem_rsp_valid) begin
          push    = 1'b1;
          state_d = (count_after_push < DepthCnt) ? StReq : StIdle;
        end else if (bus.redirect_en) begin
          fetch_pc_d = target_pc;
          state_d    = StSquash;
        end
      end
      StSquash: begin
        // Wait out the stale response; later redirects keep retargeting.
        if (bus.redirect_en) begin
          fetch_pc_d = target_pc;
        end
        if (bus.imem_rsp_valid) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FIFO pointer/occupancy bookkeeping; a redirect empties the buffer.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (bus.redirect_en) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + ptr_t'(1);
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + ptr_t'(1);
      end
      count_d = count_q + cnt_t'(push) - cnt_t'(pop);
    end
  end

  // Misalignment flag is a one-cycle echo of a redirect with nonzero low bits.
  always_comb begin
    misalign_d = bus.redirect_en & (|bus.redirect_pc_32[1:0]);
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      misalign_q <= misalign_d;
    end
  end

  // Buffer storage; contents are masked by the empty flag, so no reset needed.
  // The stored PC is the request address, i.e. fetch_pc before its +4.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= bus.imem_rsp_data_32;
      pc_mem_q[wr_ptr_q]    <= fetch_pc_q - 32'd4;
    end
  end

  assign bus.imem_req_valid = (state_q == StReq) & ~bus.redirect_en;
  assign bus.imem_addr_32   = fetch_pc_q;
  assign bus.instr_valid    = ~fifo_empty;
  assign bus.instr_32       = fifo_empty ? Nop : instr_mem_q[rd_ptr_q];
  assign bus.pc_32          = fifo_empty ? fetch_pc_q : pc_mem_q[rd_ptr_q];
  assign bus.misalign_1     = misalign_q;

endmodule

// File: doc/risc_fetch_unit.md
Name: risc_fetch_unit

Overview:
- Instruction fetch stage directly upstream of decode and the immediate sign-extend unit.
- Holds the fetch PC and issues word requests to instruction memory over a valid/ready handshake.
- Buffers returned instructions with their PC in a small FIFO and presents them to decode over a valid/ready handshake.
- Accepts PC redirects (branch/jump targets computed downstream from the extended immediate), which flush the buffer and squash any in-flight response.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset; bits [1:0] must be 0.
- FIFO_DEPTH, 2, instruction buffer entries; legal values 2..8.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_addr_32  out  32  word-aligned fetch address.
- imem_rsp_valid  in  1  response data valid.
- imem_rsp_data_32  in  32  returned instruction word.
- redirect_en  in  1  redirect PC this cycle.
- redirect_pc_32  in  32  new fetch target.
- instr_valid  out  1  buffered instruction available.
- instr_ready  in  1  decode consumes the head entry.
- instr_32  out  32  head instruction.
- pc_32  out  32  PC of the head instruction.
- misalign_1  out  1  one-cycle pulse: redirect target had bits [1:0] != 0.

Behaviour:
- Reset values, held while rst is high: state IDLE; fetch_pc = RESET_PC; FIFO empty; imem_req_valid = 0; imem_addr_32 = RESET_PC; instr_valid = 0; instr_32 = 32'h0000_0013 (NOP); pc_32 = RESET_PC; misalign_1 = 0.
- Outputs when the FIFO is empty: instr_32 = 32'h0000_0013; pc_32 = last fetch_pc.
- imem_addr_32 = fetch_pc at all times.
- imem_req_valid = (state == REQ) & ~redirect_en.
- A request is accepted when imem_req_valid & imem_req_ready.
- Address stability: while imem_req_valid is high and redirect_en is low, imem_addr_32 is stable.
- Slot reservation: a request is issued only if occupancy + 1 <= FIFO_DEPTH, counting the outstanding slot. A response therefore never overflows the FIFO.
- Limits: at most 1 outstanding request; response latency is at least 1 cycle after acceptance; peak throughput is 1 instruction per 2 cycles.
- FSM states: IDLE, REQ, WAIT, SQUASH.
  - IDLE: redirect_en -> IDLE, fetch_pc = target. Else if a slot is free -> REQ. Else stay.
  - REQ: redirect_en -> IDLE, fetch_pc = target, no request issued. Else if accepted -> WAIT, fetch_pc += 4. Else stay.
  - WAIT, imem_rsp_valid & redirect_en: drop data, fetch_pc = target -> IDLE.
  - WAIT, imem_rsp_valid only: push {fetch_pc-4, data}. Go to REQ if a slot is still free after the push (including a same-cycle pop), else IDLE.
  - WAIT, redirect_en only: fetch_pc = target -> SQUASH.
  - WAIT, otherwise: stay.
  - SQUASH: imem_rsp_valid -> drop data -> IDLE. redirect_en updates fetch_pc again. Both in the same cycle: drop the data, apply the target, -> IDLE.
- Redirect target handling: fetch_pc = {redirect_pc_32[31:2], 2'b00}.
  - misalign_1 = 1 in the cycle after a redirect whose target has bits [1:0] != 0; otherwise 0.
- Flush: redirect_en empties the FIFO at the next edge.
  - A pop in the same cycle (instr_valid & instr_ready & redirect_en) is still a completed transfer to decode.
- Output handshake: instr_valid = ~empty. Head entry is popped on instr_valid & instr_ready.
  - Push and pop in the same cycle are allowed.
  - Pop when empty is ignored.
- Stray responses: imem_rsp_valid in IDLE or REQ is ignored, with no state change.
- PC wrap: fetch_pc wraps 32'hFFFF_FFFC -> 32'h0000_0000 without error.
- Reset mid-operation: all state is cleared immediately. A response for a pre-reset request that arrives after reset is released lands in IDLE and is ignored.

Test Plan:
- Reset release, then imem_req_ready = 1 and response 1 cycle later with data 32'h00500093: request issued at addr 0; instr_valid asserted with instr_32 = 32'h00500093, pc_32 = 0; next request at addr 4.
- instr_ready = 0, DEPTH = 2, responses 32'hA, 32'hB: two entries buffered; no third request while full; after one pop, the request for addr 8 is issued.
- Redirect to 32'h100 while in WAIT; stale response 32'hDEAD arrives next cycle: the stale response is dropped; next request at 32'h100; FIFO empty in between.
- Redirect and imem_rsp_valid in the same WAIT cycle, target 32'h40: data dropped; next request at 32'h40; no SQUASH entry.
- Redirect to 32'h0000_0206: fetch_pc = 32'h204; misalign_1 pulses for exactly 1 cycle.
- Assert rst while in WAIT, then send a response after release: response ignored; FIFO empty; first request at RESET_PC.
